// File: rtl/stripe_write_sequencer_if.sv
// Handshake and data bundle between the stripe write sequencer, its control unit,
// the SRAM staging buffers and the three SD card channels.
interface stripe_write_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic              start;
    logic [31:0]       block_no;
    logic [2:0]        sd_ready;
    logic [5:0]        sd_error;
    logic              sd_start;
    logic [31:0]       sd_block_no;
    logic [1:0]        parity_sd_no;
    logic [1:0]        sram1_sd_no;
    logic [1:0]        sram2_sd_no;
    logic              sram_read_enable;
    logic [ADDR_W-1:0] sram_addr;
    logic              sd_write_enable;
    logic              busy;
    logic              done;
    logic              error;

    // Environment side: control unit plus SD card status
    modport master (
        output start, block_no, sd_ready, sd_error,
        input  sd_start, sd_block_no, parity_sd_no, sram1_sd_no, sram2_sd_no,
               sram_read_enable, sram_addr, sd_write_enable, busy, done, error
    );

    // Sequencer side
    modport slave (
        input  start, block_no, sd_ready, sd_error,
        output sd_start, sd_block_no, parity_sd_no, sram1_sd_no, sram2_sd_no,
               sram_read_enable, sram_addr, sd_write_enable, busy, done, error
    );
endinterface

// File: rtl/stripe_write_sequencer.sv
// RAID5 stripe write sequencer: rotates parity over three SD cards and streams one SRAM
// block to them. Optional macro STRIPE_RETRY_EN allows one restart of a stripe after a card error.
module stripe_write_sequencer #(
    parameter int WORDS_PER_BLOCK = 128,
    parameter int ADDR_W          = 7
) (
    input  logic                    clk,
    input  logic                    n_rst,
    stripe_write_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_START, S_WAIT_RDY, S_READ, S_WRITE, S_WAIT_DONE, S_FIN
    } state_t;

    state_t            r_state, w_state_next;
    logic [31:0]       r_block_no;
    logic [1:0]        r_parity_sd_no, r_sram1_sd_no, r_sram2_sd_no;
    logic              r_sd_start, r_sram_read_enable, r_busy, r_done, r_error;
    logic              r_fail, w_fail_next;
    logic [ADDR_W-1:0] r_sram_addr, w_sram_addr_next;
    logic              w_accept, w_all_ready, w_any_error, w_err_state, w_last_word;
    logic              w_sd_write_enable;
    logic [1:0]        w_parity_idx;
`ifdef STRIPE_RETRY_EN
    logic              r_retry, w_retry_next;
`endif

    // 4 == 1 (mod 3), so summing base-4 digits preserves the residue without a divider
    function automatic logic [1:0] mod3(input logic [31:0] v);
        logic [5:0] s;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            s = s + {4'd0, v[2*i +: 2]};
        end
        s = {4'd0, s[1:0]} + {4'd0, s[3:2]} + {4'd0, s[5:4]};
        s = {4'd0, s[1:0]} + {4'd0, s[3:2]};
        if (s >= 6'd3) begin
            s = s - 6'd3;
        end
        return s[1:0];
    endfunction

    assign w_parity_idx = mod3(r_block_no);
    assign w_all_ready  = (bus.sd_ready == 3'b111);
    assign w_any_error  = |bus.sd_error;
    assign w_last_word  = (r_sram_addr == ADDR_W'(WORDS_PER_BLOCK - 1));
    assign w_err_state  = (r_state == S_WAIT_RDY) || (r_state == S_READ) ||
                          (r_state == S_WRITE)    || (r_state == S_WAIT_DONE);

    always_comb begin
        w_state_next      = r_state;
        w_sram_addr_next  = r_sram_addr;
        w_fail_next       = r_fail;
        w_accept          = 1'b0;
        w_sd_write_enable = 1'b0;
`ifdef STRIPE_RETRY_EN
        w_retry_next      = r_retry;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef STRIPE_RETRY_EN
                w_retry_next = 1'b0;
`endif
                // busy still covers the done cycle, so a start there is ignored
                if (bus.start && !r_busy) begin
                    w_accept         = 1'b1;
                    w_state_next     = S_SETUP;
                    w_sram_addr_next = '0;
                    w_fail_next      = 1'b0;
                end
            end
            S_SETUP:    w_state_next = S_START;
            S_START:    w_state_next = S_WAIT_RDY;
            S_WAIT_RDY: if (w_all_ready) w_state_next = S_READ;
            S_READ:     w_state_next = S_WRITE;
            S_WRITE: begin
                if (w_all_ready) begin
                    w_sd_write_enable = 1'b1;
                    if (w_last_word) begin
                        w_state_next = S_WAIT_DONE;
                    end else begin
                        w_sram_addr_next = r_sram_addr + 1'b1;
                        w_state_next     = S_READ;
                    end
                end
            end
            S_WAIT_DONE: if (w_all_ready) w_state_next = S_FIN;
            S_FIN:       w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase

        // A card fault overrides readiness and suppresses the write of this cycle
        if (w_err_state && w_any_error) begin
            w_sd_write_enable = 1'b0;
            w_sram_addr_next  = r_sram_addr;
`ifdef STRIPE_RETRY_EN
            if (!r_retry) begin
                w_state_next     = S_START;
                w_sram_addr_next = '0;
                w_retry_next     = 1'b1;
            end else begin
                w_state_next = S_FIN;
                w_fail_next  = 1'b1;
            end
`else
            w_state_next = S_FIN;
            w_fail_next  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state            <= S_IDLE;
            r_block_no         <= '0;
            r_parity_sd_no     <= 2'd1;
            r_sram1_sd_no      <= 2'd2;
            r_sram2_sd_no      <= 2'd3;
            r_sd_start         <= 1'b0;
            r_sram_read_enable <= 1'b0;
            r_sram_addr        <= '0;
            r_busy             <= 1'b0;
            r_done             <= 1'b0;
            r_error            <= 1'b0;
            r_fail             <= 1'b0;
`ifdef STRIPE_RETRY_EN
            r_retry            <= 1'b0;
`endif
        end else begin
            r_state            <= w_state_next;
            r_sram_addr        <= w_sram_addr_next;
            r_fail             <= w_fail_next;
`ifdef STRIPE_RETRY_EN
            r_retry            <= w_retry_next;
`endif
            r_sd_start         <= (w_state_next == S_START);
            r_sram_read_enable <= (w_state_next == S_READ) || (w_state_next == S_WRITE);
            // done and the error flag land one cycle after FIN, busy stretches to cover them
            r_busy             <= (w_state_next != S_IDLE) || (r_state == S_FIN);
            r_done             <= (r_state == S_FIN);
            if (w_accept) begin
                r_block_no <= bus.block_no;
                r_error    <= 1'b0;
            end else if (r_state == S_FIN) begin
                r_error <= r_fail;
            end
            if (r_state == S_SETUP) begin
                case (w_parity_idx)
                    2'd0: begin
                        r_parity_sd_no <= 2'd1;
                        r_sram1_sd_no  <= 2'd2;
                        r_sram2_sd_no  <= 2'd3;
                    end
                    2'd1: begin
                        r_parity_sd_no <= 2'd2;
                        r_sram1_sd_no  <= 2'd3;
                        r_sram2_sd_no  <= 2'd1;
                    end
                    default: begin
                        r_parity_sd_no <= 2'd3;
                        r_sram1_sd_no  <= 2'd1;
                        r_sram2_sd_no  <= 2'd2;
                    end
                endcase
            end
        end
    end

    assign bus.sd_start         = r_sd_start;
    assign bus.sd_block_no      = r_block_no;
    assign bus.parity_sd_no     = r_parity_sd_no;
    assign bus.sram1_sd_no      = r_sram1_sd_no;
    assign bus.sram2_sd_no      = r_sram2_sd_no;
    assign bus.sram_read_enable = r_sram_read_enable;
    assign bus.sram_addr        = r_sram_addr;
    assign bus.sd_write_enable  = w_sd_write_enable;
    assign bus.busy             = r_busy;
    assign bus.done             = r_done;
    assign bus.error            = r_error;
endmodule

// File: tb/tb_stripe_write_sequencer.sv
// Self-checking bench for stripe_write_sequencer: expected card rotation, write order and
// completion timing come from a small arithmetic model of the stripe rules.
module tb_stripe_write_sequencer;
    localparam int W  = 128;
    localparam int AW = 7;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;

    stripe_write_sequencer_if #(.ADDR_W(AW)) bus ();

    stripe_write_sequencer #(.WORDS_PER_BLOCK(W), .ADDR_W(AW)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0       = 0;
    int rel;
    int addr_q[$];
    int bad_we, start_cnt, first_start_cyc, first_we_cyc, done_cnt, done_cyc;
    int busy_first, busy_last, err_cyc, stall_n;
    logic done_err, err_c1, stalled;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation only: records what the DUT did, cycle numbers relative to the accept edge
    always @(negedge clk) begin
        rel = cyc - t0 + 1;
        if (bus.sd_write_enable === 1'b1) begin
            if (addr_q.size() == 0) first_we_cyc = rel;
            addr_q.push_back(int'(bus.sram_addr));
            if (bus.sd_ready !== 3'b111 || bus.sd_error !== 6'd0) bad_we++;
        end
        if (bus.sd_start === 1'b1) begin
            if (start_cnt == 0) first_start_cyc = rel;
            start_cnt++;
        end
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = rel;
            done_err = bus.error;
        end
        if (bus.busy === 1'b1) begin
            if (busy_first < 0) busy_first = rel;
            busy_last = rel;
        end
        if (rel == 1) err_c1 = bus.error;
    end

    // Card rotation straight from the stripe rule: parity on card (block mod 3)+1
    function automatic logic [5:0] exp_assign(input logic [31:0] b);
        int m;
        logic [1:0] p, s1, s2;
        m  = int'(b % 32'd3);
        p  = 2'(m + 1);
        s1 = 2'((m + 1) % 3 + 1);
        s2 = 2'((m + 2) % 3 + 1);
        return {p, s1, s2};
    endfunction

    task automatic clear_mon();
        addr_q.delete();
        bad_we = 0; start_cnt = 0; first_start_cyc = -1; first_we_cyc = -1;
        done_cnt = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
        err_cyc = -1; stall_n = 0; stalled = 1'b0; done_err = 1'b0; err_c1 = 1'bx;
    endtask

    // mode: 0 clean, 1 random readiness, 2 stall at word 40, 3 error at word 10,
    //       4 extra starts while busy, 5 reset at word 50
    task automatic run_stripe(input logic [31:0] blk, input int mode);
        int   r;
        logic hit_reset = 1'b0;
        logic errd      = 1'b0;
        clear_mon();
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.block_no = blk;
        @(posedge clk); #1;
        t0           = cyc;
        bus.start    = 1'b0;
        bus.block_no = $urandom();
        for (int k = 0; k < 3000; k++) begin
            if (done_cnt != 0 || hit_reset) break;
            r = cyc - t0 + 1;
            case (mode)
                1: bus.sd_ready = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 6)) : 3'b111;
                2: begin
                    if (!stalled && bus.sram_addr == 7'd40 && bus.sram_read_enable) begin
                        stalled      = 1'b1;
                        bus.sd_ready = 3'b101;
                    end else if (stalled && stall_n < 5) begin
                        stall_n++;
                        n_checks++;
                        if (bus.sd_write_enable !== 1'b0) begin
                            n_fail++;
                            $display("FAIL stall_we: cycle %0d got %b required 0", r, bus.sd_write_enable);
                        end
                        n_checks++;
                        if (bus.sram_addr !== 7'd40) begin
                            n_fail++;
                            $display("FAIL stall_addr: cycle %0d got %0d required 40", r, bus.sram_addr);
                        end
                    end else if (stalled && stall_n == 5) begin
                        bus.sd_ready = 3'b111;
                        stall_n      = 6;
                    end
                end
                3: begin
                    if (!errd && bus.sram_addr == 7'd10 && bus.sram_read_enable) begin
                        errd         = 1'b1;
                        bus.sd_error = 6'b00_01_00;
                        err_cyc      = r;
                    end else begin
                        bus.sd_error = 6'd0;
                    end
                end
                4: begin
                    bus.start    = (r == 20 || r == 100);
                    bus.block_no = blk ^ 32'h0000_FFFF;
                end
                5: begin
                    if (bus.sram_addr == 7'd50 && bus.sram_read_enable) begin
                        n_rst     = 1'b0;
                        hit_reset = 1'b1;
                    end
                end
                default: ;
            endcase
            if (hit_reset) break;
            @(posedge clk); #1;
        end
        bus.start    = 1'b0;
        bus.sd_ready = 3'b111;
        bus.sd_error = 6'd0;
        n_checks++;
        if ((mode == 5 && !hit_reset) || (mode != 5 && done_cnt == 0)) begin
            n_fail++;
            $display("FAIL timeout: mode %0d got done_cnt %0d required completion", mode, done_cnt);
        end
        $display("stripe block=%08h mode=%0d done_cycle=%0d writes=%0d starts=%0d error=%0b",
                 blk, mode, done_cyc, addr_q.size(), start_cnt, done_err);
    endtask

    task automatic test_reset();
        n_checks++; if (bus.sd_start !== 1'b0) begin n_fail++; $display("FAIL rst_sd_start: got %b required 0", bus.sd_start); end
        n_checks++; if (bus.sram_read_enable !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b required 0", bus.sram_read_enable); end
        n_checks++; if (bus.sd_write_enable !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %b required 0", bus.sd_write_enable); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b required 0", bus.done); end
        n_checks++; if (bus.error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b required 0", bus.error); end
        n_checks++; if (bus.sram_addr !== 7'd0) begin n_fail++; $display("FAIL rst_addr: got %0d required 0", bus.sram_addr); end
        n_checks++; if (bus.sd_block_no !== 32'd0) begin n_fail++; $display("FAIL rst_block: got %h required 0", bus.sd_block_no); end
        n_checks++;
        if ({bus.parity_sd_no, bus.sram1_sd_no, bus.sram2_sd_no} !== {2'd1, 2'd2, 2'd3}) begin
            n_fail++;
            $display("FAIL rst_assign: got %0d/%0d/%0d required 1/2/3", bus.parity_sd_no, bus.sram1_sd_no, bus.sram2_sd_no);
        end
    endtask

    task automatic check_clean(input logic [31:0] blk, input int exp_done, input string tag);
        int bad_order = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad_order++;
        n_checks++; if (addr_q.size() != W) begin n_fail++; $display("FAIL %s_writes: got %0d required %0d", tag, addr_q.size(), W); end
        n_checks++; if (bad_order != 0) begin n_fail++; $display("FAIL %s_order: got %0d out-of-order writes required 0", tag, bad_order); end
        n_checks++; if (bad_we != 0) begin n_fail++; $display("FAIL %s_we_gate: got %0d ungated writes required 0", tag, bad_we); end
        n_checks++; if (start_cnt != 1) begin n_fail++; $display("FAIL %s_sd_start: got %0d pulses required 1", tag, start_cnt); end
        n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL %s_error: got %b required 0", tag, done_err); end
        n_checks++;
        if ({bus.parity_sd_no, bus.sram1_sd_no, bus.sram2_sd_no} !== exp_assign(blk)) begin
            n_fail++;
            $display("FAIL %s_assign: got %0d/%0d/%0d required %0d/%0d/%0d", tag, bus.parity_sd_no,
                     bus.sram1_sd_no, bus.sram2_sd_no, exp_assign(blk) >> 4, (exp_assign(blk) >> 2) & 6'd3, exp_assign(blk) & 6'd3);
        end
        n_checks++; if (bus.sd_block_no !== blk) begin n_fail++; $display("FAIL %s_block_no: got %h required %h", tag, bus.sd_block_no, blk); end
        if (exp_done > 0) begin
            n_checks++; if (done_cyc != exp_done) begin n_fail++; $display("FAIL %s_done_cycle: got %0d required %0d", tag, done_cyc, exp_done); end
        end
    endtask

    task automatic test_basic();
        run_stripe(32'd0, 0);
        check_clean(32'd0, 6 + 2 * W, "basic");
        n_checks++; if (first_start_cyc != 2) begin n_fail++; $display("FAIL basic_start_cycle: got %0d required 2", first_start_cyc); end
        n_checks++; if (first_we_cyc != 5) begin n_fail++; $display("FAIL basic_first_we: got %0d required 5", first_we_cyc); end
        n_checks++; if (busy_first != 1) begin n_fail++; $display("FAIL basic_busy_first: got %0d required 1", busy_first); end
        n_checks++; if (busy_last != 6 + 2 * W) begin n_fail++; $display("FAIL basic_busy_last: got %0d required %0d", busy_last, 6 + 2 * W); end
    endtask

    task automatic test_assignment();
        // 0xABCDEFAB is a multiple of 3, so it lands parity on card 1
        logic [31:0] blks[6];
        blks[0] = 32'd1; blks[1] = 32'hABCD_EFAB; blks[2] = 32'd2; blks[3] = 32'hFFFF_FFFF;
        blks[4] = $urandom(); blks[5] = $urandom();
        foreach (blks[i]) begin
            run_stripe(blks[i], 0);
            check_clean(blks[i], 6 + 2 * W, "assign");
        end
    endtask

    task automatic test_random_ready();
        logic [31:0] b;
        for (int i = 0; i < 3; i++) begin
            b = $urandom();
            run_stripe(b, 1);
            check_clean(b, 0, "rand");
            n_checks++; if (done_cyc < 6 + 2 * W) begin n_fail++; $display("FAIL rand_done_cycle: got %0d required >= %0d", done_cyc, 6 + 2 * W); end
        end
    endtask

    task automatic test_stall();
        run_stripe(32'd5, 2);
        check_clean(32'd5, 6 + 2 * W + 5, "stall");
        n_checks++; if (stall_n != 6) begin n_fail++; $display("FAIL stall_reached: got %0d required 6", stall_n); end
    endtask

    task automatic test_error();
        int bad_order = 0;
        run_stripe(32'd7, 3);
        n_checks++; if (err_cyc < 0) begin n_fail++; $display("FAIL err_injected: got %0d required word 10 reached", err_cyc); end
`ifdef STRIPE_RETRY_EN
        for (int i = 0; i < W && addr_q.size() >= W; i++) if (addr_q[addr_q.size() - W + i] != i) bad_order++;
        n_checks++; if (start_cnt != 2) begin n_fail++; $display("FAIL retry_sd_start: got %0d required 2", start_cnt); end
        n_checks++; if (addr_q.size() != 10 + W) begin n_fail++; $display("FAIL retry_writes: got %0d required %0d", addr_q.size(), 10 + W); end
        n_checks++; if (bad_order != 0) begin n_fail++; $display("FAIL retry_order: got %0d bad required 0", bad_order); end
        n_checks++; if (done_err !== 1'b0) begin n_fail++; $display("FAIL retry_error: got %b required 0", done_err); end
`else
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] != i) bad_order++;
        n_checks++; if (done_cyc != err_cyc + 2) begin n_fail++; $display("FAIL err_done_cycle: got %0d required %0d", done_cyc, err_cyc + 2); end
        n_checks++; if (addr_q.size() != 10) begin n_fail++; $display("FAIL err_writes: got %0d required 10", addr_q.size()); end
        n_checks++; if (bad_order != 0) begin n_fail++; $display("FAIL err_order: got %0d bad required 0", bad_order); end
        n_checks++; if (done_err !== 1'b1) begin n_fail++; $display("FAIL err_flag: got %b required 1", done_err); end
        n_checks++; if (bus.error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b required 1", bus.error); end
        n_checks++; if (start_cnt != 1) begin n_fail++; $display("FAIL err_sd_start: got %0d required 1", start_cnt); end
`endif
    endtask

    task automatic test_busy_start();
        run_stripe(32'd9, 4);
        repeat (20) @(posedge clk);
        #1;
        check_clean(32'd9, 6 + 2 * W, "busy");
        n_checks++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL busy_err_clear: got %b required 0", err_c1); end
        n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL busy_done_cnt: got %0d required 1", done_cnt); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle: got %b required 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        run_stripe(32'd11, 5);
        #1;
        test_reset();
        repeat (4) @(posedge clk);
        #1;
        n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL rstmid_done: got %0d required 0", done_cnt); end
        n_rst = 1'b1;
        run_stripe(32'd12, 0);
        check_clean(32'd12, 6 + 2 * W, "rstmid");
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no end of test required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.block_no = 32'd0;
        bus.sd_ready = 3'b111;
        bus.sd_error = 6'd0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        n_rst = 1'b1;
        test_basic();
        test_assignment();
        test_random_ready();
        test_stall();
        test_error();
        test_busy_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
